// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code and scheduler state enums, plus the common
// add/sub/and/or evaluation used by every block that time-shares the ALU.
package alu_pkg;

  localparam int ALU_MAX_W = 32;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Callers zero-extend W-bit operands; bit W of the return value is then the
  // carry (add) or borrow (sub), and zero for the bitwise ops.
  function automatic logic [ALU_MAX_W:0] alu_compute(
    input alu_op_e                op,
    input logic [ALU_MAX_W-1:0]   a,
    input logic [ALU_MAX_W-1:0]   b
  );
    logic [ALU_MAX_W:0] ax;
    logic [ALU_MAX_W:0] bx;
    logic [ALU_MAX_W:0] r;
    ax = {1'b0, a};
    bx = {1'b0, b};
    case (op)
      ALU_ADD: r = ax + bx;
      ALU_SUB: r = ax - bx;
      ALU_AND: r = ax & bx;
      ALU_OR:  r = ax | bx;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or
// after ptr, wrapping at N.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] rot_idx [N];
  logic [N-1:0]     rot_req;

  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign rot_idx[gi] = (int'(ptr) + gi >= N) ? IDX_W'(int'(ptr) + gi - N)
                                                : IDX_W'(int'(ptr) + gi);
    assign rot_req[gi] = req[rot_idx[gi]];
  end

  // Scan from the far end so the candidate closest to ptr is written last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        grant             = '0;
        grant[rot_idx[k]] = 1'b1;
        grant_idx         = rot_idx[k];
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one add/sub/and/or ALU between NUM_REQ requesters: round-robin
// accept, one execute cycle, then a held response tagged with the owner ID.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_carry,
  output logic                     busy
);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  alu_op_e          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [WIDTH:0]     alu_out;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // The only combinational input-to-output path: valid -> ready while idle.
  assign req_ready  = (state_q == ST_IDLE && rst_n) ? grant : '0;
  assign busy       = (state_q != ST_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_id_d     = rsp_id_q;
    alu_out      = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          op_d     = alu_op_e'(req_op[2*int'(grant_idx) +: 2]);
          a_d      = req_a[WIDTH*int'(grant_idx) +: WIDTH];
          b_d      = req_b[WIDTH*int'(grant_idx) +: WIDTH];
          id_d     = grant_idx;
          rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_out      = (WIDTH+1)'(alu_compute(op_q, ALU_MAX_W'(a_q), ALU_MAX_W'(b_q)));
        rsp_result_d = alu_out[WIDTH-1:0];
        rsp_carry_d  = alu_out[WIDTH];
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      op_q         <= ALU_ADD;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_alu_rr_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [2*N-1:0] req_op = '0;
  logic [W*N-1:0] req_a = '0;
  logic [W*N-1:0] req_b = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_result;
  logic           rsp_carry;
  logic           busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] id;
    logic [7:0] res;
    logic       cy;
    int         due;
  } exp_t;

  alu_rr_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] ref_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int ai;
    int bi;
    int r;
    logic c;
    logic [8:0] v;
    ai = int'(a);
    bi = int'(b);
    case (op)
      2'd0: begin r = ai + bi; c = (r > 255); r = r % 256; end
      2'd1: begin c = (ai < bi); r = ai - bi; if (r < 0) r = r + 256; end
      2'd2: begin r = ai & bi; c = 1'b0; end
      default: begin r = ai | bi; c = 1'b0; end
    endcase
    v[8]   = c;
    v[7:0] = 8'(r);
    return v;
  endfunction

  function automatic int ref_winner(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    req_valid[i]    = 1'b1;
    req_op[2*i +: 2] = op;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready_forced got=%b want=0000", req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if ({rsp_result, rsp_carry, rsp_id} !== 11'd0) begin bad++; $display("FAIL reset_rsp_fields got=%h/%b/%0d want=0", rsp_result, rsp_carry, rsp_id); end
    @(posedge clk); #1;
    req_valid = '0;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL idle_no_valid got ready=%b busy=%b want 0000/0", req_ready, busy); end
    $display("txn reset checked");
  endtask

  task automatic test_single_add();
    do_reset();
    set_req(0, 2'b00, 8'hF0, 8'h20);
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL add_accept got=%b want=0001", req_ready); end
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin bad++; $display("FAIL add_exec got busy=%b rsp_valid=%b ready=%b want 1/0/0000", busy, rsp_valid, req_ready); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL add_rsp_valid got=%b want=1", rsp_valid); end
    total++; if (rsp_result !== 8'h10 || rsp_carry !== 1'b1 || rsp_id !== 2'd0) begin bad++; $display("FAIL add_rsp got=%h/%b/%0d want=10/1/0", rsp_result, rsp_carry, rsp_id); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL add_back_idle got busy=%b want=0", busy); end
    $display("txn add id=0 result=%h carry=%b", rsp_result, rsp_carry);
  endtask

  task automatic test_ops();
    logic [1:0] t_op  [3] = '{2'b01, 2'b10, 2'b11};
    logic [7:0] t_a   [3] = '{8'h03, 8'hCC, 8'hCC};
    logic [7:0] t_b   [3] = '{8'h05, 8'hAA, 8'hAA};
    logic [7:0] t_res [3] = '{8'hFE, 8'h88, 8'hEE};
    logic       t_cy  [3] = '{1'b1, 1'b0, 1'b0};
    do_reset();
    for (int t = 0; t < 3; t++) begin
      set_req(2, t_op[t], t_a[t], t_b[t]);
      @(negedge clk);
      total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL ops_accept[%0d] got=%b want=0100", t, req_ready); end
      @(posedge clk); #1 req_valid[2] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin bad++; $display("FAIL ops_rsp_hdr[%0d] got valid=%b id=%0d want 1/2", t, rsp_valid, rsp_id); end
      total++; if (rsp_result !== t_res[t] || rsp_carry !== t_cy[t]) begin bad++; $display("FAIL ops_rsp[%0d] got=%h/%b want=%h/%b", t, rsp_result, rsp_carry, t_res[t], t_cy[t]); end
      $display("txn op=%0d id=2 result=%h carry=%b", t_op[t], rsp_result, rsp_carry);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rotation();
    logic [7:0] pa [N];
    logic [7:0] pb [N];
    int gid[$];
    int gcyc[$];
    exp_t q[$];
    exp_t e;
    logic [8:0] calc;
    int w;
    do_reset();
    for (int i = 0; i < N; i++) begin
      pa[i] = 8'($urandom);
      pb[i] = 8'($urandom);
      set_req(i, 2'(i), pa[i], pb[i]);
    end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      total++; if ($countones(req_ready) > 1) begin bad++; $display("FAIL rot_onehot cycle=%0d got=%b want at most one bit", c, req_ready); end
      if (req_ready != 0) begin
        w = 0;
        for (int k = 0; k < N; k++) if (req_ready[k]) w = k;
        gid.push_back(w);
        gcyc.push_back(c);
        calc = ref_alu(2'(w), pa[w], pb[w]);
        e.id = 2'(w); e.res = calc[7:0]; e.cy = calc[8]; e.due = c + 2;
        q.push_back(e);
      end
      if (rsp_valid) begin
        total++;
        if (q.size() == 0) begin bad++; $display("FAIL rot_rsp_unexpected cycle=%0d got id=%0d want no response", c, rsp_id); end
        else begin
          e = q.pop_front();
          if (rsp_id !== e.id || rsp_result !== e.res || rsp_carry !== e.cy) begin bad++; $display("FAIL rot_rsp cycle=%0d got=%0d/%h/%b want=%0d/%h/%b", c, rsp_id, rsp_result, rsp_carry, e.id, e.res, e.cy); end
          $display("txn rot id=%0d result=%h carry=%b", rsp_id, rsp_result, rsp_carry);
        end
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    total++; if (gid.size() != 5) begin bad++; $display("FAIL rot_grant_count got=%0d want=5", gid.size()); end
    for (int k = 0; k < gid.size() && k < 5; k++) begin
      total++; if (gid[k] != k % N) begin bad++; $display("FAIL rot_order[%0d] got=%0d want=%0d", k, gid[k], k % N); end
      if (k > 0) begin
        total++; if (gcyc[k] - gcyc[k-1] != 3) begin bad++; $display("FAIL rot_gap[%0d] got=%0d want=3", k, gcyc[k] - gcyc[k-1]); end
      end
    end
    total++; if (q.size() != 0) begin bad++; $display("FAIL rot_missing_rsp got=%0d outstanding want=0", q.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 2'b00, 8'h7F, 8'h01);
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_accept0 got=%b want=0001", req_ready); end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    set_req(1, 2'b01, 8'h10, 8'h20);
    @(negedge clk);
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_exec_ready got=%b want=0000", req_ready); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 1'b1 || rsp_result !== 8'h80 || rsp_carry !== 1'b0 || rsp_id !== 2'd0) begin bad++; $display("FAIL bp_hold[%0d] got=%b/%h/%b/%0d want=1/80/0/0", k, rsp_valid, rsp_result, rsp_carry, rsp_id); end
      total++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin bad++; $display("FAIL bp_stall[%0d] got ready=%b busy=%b want 0000/1", k, req_ready, busy); end
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin bad++; $display("FAIL bp_release got valid=%b ready=%b want 1/0000", rsp_valid, req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_accept1 got=%b want=0010", req_ready); end
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 8'hF0 || rsp_carry !== 1'b1) begin bad++; $display("FAIL bp_rsp1 got=%b/%0d/%h/%b want=1/1/f0/1", rsp_valid, rsp_id, rsp_result, rsp_carry); end
    $display("txn backpressure id=1 result=%h carry=%b", rsp_result, rsp_carry);
    @(posedge clk); #1;
  endtask

  task automatic test_ptr_wrap();
    do_reset();
    set_req(3, 2'b00, 8'h01, 8'h02);
    @(negedge clk);
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_accept3 got=%b want=1000", req_ready); end
    @(posedge clk); #1 req_valid[3] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (rsp_id !== 2'd3 || rsp_result !== 8'h03) begin bad++; $display("FAIL wrap_rsp3 got=%0d/%h want=3/03", rsp_id, rsp_result); end
    @(posedge clk); #1;
    set_req(0, 2'b10, 8'hF0, 8'h3C);
    set_req(2, 2'b11, 8'h0F, 8'h30);
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wrap_first got=%b want=0001", req_ready); end
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (rsp_id !== 2'd0 || rsp_result !== 8'h30) begin bad++; $display("FAIL wrap_rsp0 got=%0d/%h want=0/30", rsp_id, rsp_result); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL wrap_second got=%b want=0100", req_ready); end
    @(posedge clk); #1 req_valid[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (rsp_id !== 2'd2 || rsp_result !== 8'h3F) begin bad++; $display("FAIL wrap_rsp2 got=%0d/%h want=2/3f", rsp_id, rsp_result); end
    $display("txn wrap order 3,0,2 checked");
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(1, 2'b00, 8'h11, 8'h22);
    @(negedge clk);
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rmid_accept1 got=%b want=0010", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    rst_n     = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || {rsp_result, rsp_carry, rsp_id} !== 11'd0) begin bad++; $display("FAIL rmid_exec_reset got busy=%b valid=%b fields=%h/%b/%0d want all 0", busy, rsp_valid, rsp_result, rsp_carry, rsp_id); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_stale_exec[%0d] got valid=%b busy=%b want 0/0", k, rsp_valid, busy); end
    end
    @(posedge clk); #1;
    set_req(2, 2'b01, 8'h40, 8'h01);
    @(negedge clk);
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rmid_accept2 got=%b want=0100", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rmid_in_resp got valid=%b want=1", rsp_valid); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || {rsp_result, rsp_carry, rsp_id} !== 11'd0) begin bad++; $display("FAIL rmid_resp_reset got busy=%b valid=%b fields=%h/%b/%0d want all 0", busy, rsp_valid, rsp_result, rsp_carry, rsp_id); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale_resp[%0d] got valid=%b want=0", k, rsp_valid); end
    end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) set_req(i, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_ptr_restart got=%b want=0001", req_ready); end
    $display("txn reset mid-operation checked");
    @(posedge clk); #1 req_valid = '0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_random();
    exp_t exp_q[$];
    exp_t e;
    logic [8:0] calc;
    logic [N-1:0] exp_ready;
    int m_ptr;
    int avail_cycle;
    bit avail;
    bit due;
    int w;
    do_reset();
    m_ptr       = 0;
    avail       = 1'b1;
    avail_cycle = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      w = (avail && c >= avail_cycle) ? ref_winner(req_valid, m_ptr) : -1;
      exp_ready = (w >= 0) ? N'(1 << w) : '0;
      total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready cycle=%0d got=%b want=%b", c, req_ready, exp_ready); end
      if (w >= 0) begin
        calc  = ref_alu(req_op[2*w +: 2], req_a[8*w +: 8], req_b[8*w +: 8]);
        e.id  = 2'(w); e.res = calc[7:0]; e.cy = calc[8]; e.due = c + 2;
        exp_q.push_back(e);
        avail = 1'b0;
        m_ptr = (w + 1) % N;
      end
      due = (exp_q.size() > 0) && (c >= exp_q[0].due);
      total++;
      if (rsp_valid !== due) begin
        bad++; $display("FAIL rnd_rsp_valid cycle=%0d got=%b want=%b", c, rsp_valid, due);
      end else if (due) begin
        total++;
        if (rsp_id !== exp_q[0].id || rsp_result !== exp_q[0].res || rsp_carry !== exp_q[0].cy) begin
          bad++; $display("FAIL rnd_rsp cycle=%0d got=%0d/%h/%b want=%0d/%h/%b", c, rsp_id, rsp_result, rsp_carry, exp_q[0].id, exp_q[0].res, exp_q[0].cy);
        end
        if (rsp_ready) begin
          $display("txn rnd id=%0d result=%h carry=%b", rsp_id, rsp_result, rsp_carry);
          void'(exp_q.pop_front());
          avail       = 1'b1;
          avail_cycle = c + 1;
        end
      end
      @(posedge clk); #1;
      if (w >= 0) req_valid[w] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 2'($urandom), 8'($urandom), 8'($urandom));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_ops();
    test_rotation();
    test_backpressure();
    test_ptr_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
